// File: rtl/alu_resolve_wb_pkg.sv
// Shared widths and writeback entry layout for the ALU resolve/writeback stage.
package alu_resolve_wb_pkg;

  localparam int XLEN                 = 64;
  localparam int VIRTUAL_ADDR_LEN     = 39;
  localparam int PHY_REG_ADDR_WIDTH   = 6;
  localparam int ROB_INDEX_WIDTH      = 6;
  localparam int EXCEPTION_CODE_WIDTH = 4;

  typedef struct packed {
    logic [PHY_REG_ADDR_WIDTH-1:0]   rd;
    logic [ROB_INDEX_WIDTH-1:0]      rob;
    logic [XLEN-1:0]                 data;
    logic                            we;
    logic                            exc;
    logic [EXCEPTION_CODE_WIDTH-1:0] ecause;
  } wb_entry_t;

  localparam int WB_ENTRY_W = $bits(wb_entry_t);

  function automatic logic [VIRTUAL_ADDR_LEN-1:0] seq_pc(input logic [VIRTUAL_ADDR_LEN-1:0] pc);
    return pc + VIRTUAL_ADDR_LEN'(4);
  endfunction

endpackage

// File: rtl/alu_resolve_wb_fifo.sv
// Two-entry skid FIFO with valid/ready output; head entry drives the consumer directly.
module wb_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] head_data
);

  logic [W-1:0] mem_reg [2];
  logic         wptr_reg;
  logic         rptr_reg;
  logic [1:0]   count_reg;
  logic         do_push;
  logic         pop;

  assign valid     = (count_reg != 2'd0);
  assign full      = (count_reg == 2'd2);
  assign pop       = valid & ready;
  assign do_push   = push & ~full;
  assign head_data = mem_reg[rptr_reg];

  // Flush only rewinds pointers; stale slot contents are never visible because valid drops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_reg   <= 1'b0;
      rptr_reg   <= 1'b0;
      count_reg  <= 2'd0;
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
    end else if (flush) begin
      wptr_reg  <= 1'b0;
      rptr_reg  <= 1'b0;
      count_reg <= 2'd0;
    end else begin
      if (do_push) begin
        mem_reg[wptr_reg] <= push_data;
        wptr_reg          <= ~wptr_reg;
      end
      if (pop) rptr_reg <= ~rptr_reg;
      count_reg <= count_reg + {1'b0, do_push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/alu_resolve_wb.sv
// Resolves branch/jump outcome of the registered ALU result, pulses redirect and
// predictor training, and queues the writeback toward the shared WB/ROB port.
module alu_resolve_wb
  import alu_resolve_wb_pkg::*;
(
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            flush,
  input  logic                            done_i,
  input  logic [PHY_REG_ADDR_WIDTH-1:0]   rd_addr_i,
  input  logic [ROB_INDEX_WIDTH-1:0]      rob_index_i,
  input  logic [XLEN-1:0]                 alu_result_i,
  input  logic                            cmp_result_i,
  input  logic                            jump_i,
  input  logic                            branch_i,
  input  logic [VIRTUAL_ADDR_LEN-1:0]     pc_i,
  input  logic [VIRTUAL_ADDR_LEN-1:0]     next_pc_i,
  input  logic                            exception_valid_i,
  input  logic [EXCEPTION_CODE_WIDTH-1:0] ecause_i,
  output logic                            stall_o,
  output logic                            wb_valid_o,
  input  logic                            wb_ready_i,
  output logic [PHY_REG_ADDR_WIDTH-1:0]   wb_rd_addr_o,
  output logic [ROB_INDEX_WIDTH-1:0]      wb_rob_index_o,
  output logic [XLEN-1:0]                 wb_data_o,
  output logic                            wb_we_o,
  output logic                            wb_exception_o,
  output logic [EXCEPTION_CODE_WIDTH-1:0] wb_ecause_o,
  output logic                            redirect_o,
  output logic [VIRTUAL_ADDR_LEN-1:0]     redirect_pc_o,
  output logic                            bp_update_o,
  output logic [VIRTUAL_ADDR_LEN-1:0]     bp_pc_o,
  output logic                            bp_taken_o,
  output logic [VIRTUAL_ADDR_LEN-1:0]     bp_target_o,
  output logic                            bp_is_jump_o
);

  logic                        is_ctrl;
  logic                        taken;
  logic                        mispredict;
  logic                        live;
  logic [VIRTUAL_ADDR_LEN-1:0] fall_pc;
  logic [VIRTUAL_ADDR_LEN-1:0] target_pc;
  logic [VIRTUAL_ADDR_LEN-1:0] actual_pc;
  logic                        fifo_full;
  wb_entry_t                   in_entry;
  wb_entry_t                   head_entry;

  logic                        redirect_reg;
  logic [VIRTUAL_ADDR_LEN-1:0] redirect_pc_reg;
  logic                        bp_update_reg;
  logic [VIRTUAL_ADDR_LEN-1:0] bp_pc_reg;
  logic                        bp_taken_reg;
  logic [VIRTUAL_ADDR_LEN-1:0] bp_target_reg;
  logic                        bp_is_jump_reg;

  assign live       = done_i & ~flush;
  assign is_ctrl    = jump_i | branch_i;
  assign taken      = jump_i | (branch_i & cmp_result_i);
  assign fall_pc    = seq_pc(pc_i);
  assign target_pc  = alu_result_i[VIRTUAL_ADDR_LEN-1:0];
  assign actual_pc  = taken ? target_pc : fall_pc;
  assign mispredict = is_ctrl & ~exception_valid_i & (actual_pc != next_pc_i);

  always_comb begin
    in_entry        = '0;
    in_entry.rd     = rd_addr_i;
    in_entry.rob    = rob_index_i;
    in_entry.data   = jump_i ? {{(XLEN-VIRTUAL_ADDR_LEN){1'b0}}, fall_pc} : alu_result_i;
    in_entry.we     = ~branch_i & ~exception_valid_i;
    in_entry.exc    = exception_valid_i;
    in_entry.ecause = exception_valid_i ? ecause_i : '0;
  end

  wb_skid_fifo #(.W(WB_ENTRY_W)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .push      (live),
    .push_data (in_entry),
    .full      (fifo_full),
    .valid     (wb_valid_o),
    .ready     (wb_ready_i),
    .head_data (head_entry)
  );

  assign stall_o        = fifo_full;
  assign wb_rd_addr_o   = head_entry.rd;
  assign wb_rob_index_o = head_entry.rob;
  assign wb_data_o      = head_entry.data;
  assign wb_we_o        = head_entry.we;
  assign wb_exception_o = head_entry.exc;
  assign wb_ecause_o    = head_entry.ecause;

  // Resolution happens at enqueue time, so these pulses ignore writeback back-pressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      redirect_reg    <= 1'b0;
      redirect_pc_reg <= '0;
      bp_update_reg   <= 1'b0;
      bp_pc_reg       <= '0;
      bp_taken_reg    <= 1'b0;
      bp_target_reg   <= '0;
      bp_is_jump_reg  <= 1'b0;
    end else begin
      redirect_reg  <= live & mispredict;
      bp_update_reg <= live & is_ctrl;
      if (live) begin
        redirect_pc_reg <= actual_pc;
        bp_pc_reg       <= pc_i;
        bp_taken_reg    <= taken;
        bp_target_reg   <= target_pc;
        bp_is_jump_reg  <= jump_i;
      end
    end
  end

  assign redirect_o    = redirect_reg;
  assign redirect_pc_o = redirect_pc_reg;
  assign bp_update_o   = bp_update_reg;
  assign bp_pc_o       = bp_pc_reg;
  assign bp_taken_o    = bp_taken_reg;
  assign bp_target_o   = bp_target_reg;
  assign bp_is_jump_o  = bp_is_jump_reg;

  // The ALU must honour stall_o; a result offered while full would be lost.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rstn)
    !(done_i && !flush && stall_o));

endmodule

// File: tb/tb_alu_resolve_wb.sv
// Directed bench for alu_resolve_wb with a queue-based reference model checked every cycle.
module tb_alu_resolve_wb;
  import alu_resolve_wb_pkg::*;

  localparam int VA = VIRTUAL_ADDR_LEN;

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic            flush = 1'b0;
  logic            done_i = 1'b0;
  logic [5:0]      rd_addr_i = '0;
  logic [5:0]      rob_index_i = '0;
  logic [63:0]     alu_result_i = '0;
  logic            cmp_result_i = 1'b0;
  logic            jump_i = 1'b0;
  logic            branch_i = 1'b0;
  logic [VA-1:0]   pc_i = '0;
  logic [VA-1:0]   next_pc_i = '0;
  logic            exception_valid_i = 1'b0;
  logic [3:0]      ecause_i = '0;
  logic            wb_ready_i = 1'b0;
  logic            stall_o, wb_valid_o, wb_we_o, wb_exception_o;
  logic [5:0]      wb_rd_addr_o, wb_rob_index_o;
  logic [63:0]     wb_data_o;
  logic [3:0]      wb_ecause_o;
  logic            redirect_o, bp_update_o, bp_taken_o, bp_is_jump_o;
  logic [VA-1:0]   redirect_pc_o, bp_pc_o, bp_target_o;

  always #5 clk = ~clk;

  alu_resolve_wb dut (
    .clk(clk), .rstn(rstn), .flush(flush), .done_i(done_i),
    .rd_addr_i(rd_addr_i), .rob_index_i(rob_index_i), .alu_result_i(alu_result_i),
    .cmp_result_i(cmp_result_i), .jump_i(jump_i), .branch_i(branch_i),
    .pc_i(pc_i), .next_pc_i(next_pc_i), .exception_valid_i(exception_valid_i),
    .ecause_i(ecause_i), .stall_o(stall_o), .wb_valid_o(wb_valid_o),
    .wb_ready_i(wb_ready_i), .wb_rd_addr_o(wb_rd_addr_o), .wb_rob_index_o(wb_rob_index_o),
    .wb_data_o(wb_data_o), .wb_we_o(wb_we_o), .wb_exception_o(wb_exception_o),
    .wb_ecause_o(wb_ecause_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .bp_update_o(bp_update_o), .bp_pc_o(bp_pc_o), .bp_taken_o(bp_taken_o),
    .bp_target_o(bp_target_o), .bp_is_jump_o(bp_is_jump_o)
  );

  typedef struct {
    logic [5:0]  rd;
    logic [5:0]  rob;
    logic [63:0] data;
    logic        we;
    logic        exc;
    logic [3:0]  ecause;
  } exp_t;

  exp_t          q[$];
  exp_t          m_ent;
  int            m_sz;
  logic          m_taken;
  logic [VA-1:0] m_actual;
  logic          e_redir = 1'b0;
  logic [VA-1:0] e_redir_pc = '0;
  logic          e_bp = 1'b0;
  logic [VA-1:0] e_bp_pc = '0;
  logic          e_bp_taken = 1'b0;
  logic [VA-1:0] e_bp_target = '0;
  logic          e_bp_jump = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: a queue of at most two results, plus the expected pulse outputs.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q.delete();
      e_redir <= 1'b0;
      e_bp    <= 1'b0;
    end else if (flush) begin
      q.delete();
      e_redir <= 1'b0;
      e_bp    <= 1'b0;
    end else begin
      m_sz     = q.size();
      m_taken  = jump_i || (branch_i && cmp_result_i);
      m_actual = m_taken ? alu_result_i[VA-1:0] : pc_i + 39'd4;
      m_ent.rd     = rd_addr_i;
      m_ent.rob    = rob_index_i;
      m_ent.data   = jump_i ? {25'd0, pc_i + 39'd4} : alu_result_i;
      m_ent.we     = !branch_i && !exception_valid_i;
      m_ent.exc    = exception_valid_i;
      m_ent.ecause = ecause_i;
      if (m_sz > 0 && wb_ready_i) void'(q.pop_front());
      if (done_i && m_sz < 2) q.push_back(m_ent);
      e_redir     <= done_i && (jump_i || branch_i) && !exception_valid_i && (m_actual != next_pc_i);
      e_bp        <= done_i && (jump_i || branch_i);
      e_redir_pc  <= m_actual;
      e_bp_pc     <= pc_i;
      e_bp_taken  <= m_taken;
      e_bp_target <= alu_result_i[VA-1:0];
      e_bp_jump   <= jump_i;
    end
  end

  always @(negedge clk) begin
    if (rstn !== 1'bx) begin
      check("stall", stall_o, q.size() == 2);
      check("wb_valid", wb_valid_o, q.size() != 0);
      if (q.size() != 0) begin
        check("wb_rd", wb_rd_addr_o, q[0].rd);
        check("wb_rob", wb_rob_index_o, q[0].rob);
        check("wb_data", wb_data_o, q[0].data);
        check("wb_we", wb_we_o, q[0].we);
        check("wb_exc", wb_exception_o, q[0].exc);
        if (q[0].exc) check("wb_ecause", wb_ecause_o, q[0].ecause);
      end
      check("redirect", redirect_o, e_redir);
      if (e_redir) check("redirect_pc", redirect_pc_o, e_redir_pc);
      check("bp_update", bp_update_o, e_bp);
      if (e_bp) begin
        check("bp_pc", bp_pc_o, e_bp_pc);
        check("bp_taken", bp_taken_o, e_bp_taken);
        check("bp_target", bp_target_o, e_bp_target);
        check("bp_is_jump", bp_is_jump_o, e_bp_jump);
      end
    end
  end

  task automatic send(input logic j, input logic b, input logic c,
                      input logic [VA-1:0] pc, input logic [VA-1:0] npc,
                      input logic [63:0] res, input logic [5:0] rd, input logic [5:0] rob,
                      input logic exc, input logic [3:0] ec);
    int k = 0;
    while (stall_o && k < 64) begin
      @(posedge clk); #1;
      k++;
    end
    if (stall_o) check("stall_timeout", stall_o, 1'b0);
    done_i = 1'b1; jump_i = j; branch_i = b; cmp_result_i = c;
    pc_i = pc; next_pc_i = npc; alu_result_i = res;
    rd_addr_i = rd; rob_index_i = rob; exception_valid_i = exc; ecause_i = ec;
    @(posedge clk); #1;
    done_i = 1'b0; jump_i = 1'b0; branch_i = 1'b0; exception_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    #2 rstn = 1'b0;
    idle(2);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_wb_data", wb_data_o, 0);
    check("rst_redirect", redirect_o, 0);
    check("rst_bp_update", bp_update_o, 0);
    rstn = 1'b1;
    idle(1);
    wb_ready_i = 1'b1;

    // plain ALU op
    send(0, 0, 0, 39'h100, 39'h104, 64'h10, 6'd5, 6'd3, 0, 4'd0);
    check("add_valid", wb_valid_o, 1);
    check("add_we", wb_we_o, 1);
    check("add_data", wb_data_o, 64'h10);
    check("add_rob", wb_rob_index_o, 3);
    check("add_rd", wb_rd_addr_o, 5);
    check("add_redirect", redirect_o, 0);

    // taken branch, predicted fall-through
    send(0, 1, 1, 39'h1000, 39'h1004, 64'h1040, 6'd7, 6'd4, 0, 4'd0);
    check("br_redirect", redirect_o, 1);
    check("br_redirect_pc", redirect_pc_o, 39'h1040);
    check("br_bp_taken", bp_taken_o, 1);
    check("br_we", wb_we_o, 0);

    // correctly predicted jump
    send(1, 0, 0, 39'h2000, 39'h3000, 64'h3000, 6'd8, 6'd5, 0, 4'd0);
    check("jmp_redirect", redirect_o, 0);
    check("jmp_data", wb_data_o, 64'h2004);
    check("jmp_bp_update", bp_update_o, 1);
    check("jmp_bp_is_jump", bp_is_jump_o, 1);
    idle(1);
    check("drained", wb_valid_o, 0);

    // back-pressure: fill, stall, then drain in order
    wb_ready_i = 1'b0;
    send(0, 0, 0, 39'h300, 39'h304, 64'hA1, 6'd1, 6'd10, 0, 4'd0);
    check("bp1_stall", stall_o, 0);
    send(0, 0, 0, 39'h304, 39'h308, 64'hA2, 6'd2, 6'd11, 0, 4'd0);
    check("bp2_stall", stall_o, 1);
    check("bp2_head", wb_data_o, 64'hA1);
    idle(1);
    check("bp_hold_head", wb_data_o, 64'hA1);
    wb_ready_i = 1'b1;
    send(0, 0, 0, 39'h308, 39'h30c, 64'hA3, 6'd3, 6'd12, 0, 4'd0);
    check("bp3_head", wb_data_o, 64'hA3);
    check("bp3_stall", stall_o, 0);
    idle(1);

    // flush with two queued and an incoming mispredict
    wb_ready_i = 1'b0;
    send(0, 0, 0, 39'h400, 39'h404, 64'hB1, 6'd4, 6'd20, 0, 4'd0);
    send(0, 0, 0, 39'h404, 39'h408, 64'hB2, 6'd5, 6'd21, 0, 4'd0);
    done_i = 1'b1; branch_i = 1'b1; cmp_result_i = 1'b1;
    pc_i = 39'h5000; next_pc_i = 39'h5004; alu_result_i = 64'h6000; flush = 1'b1;
    idle(1);
    done_i = 1'b0; branch_i = 1'b0; flush = 1'b0;
    check("fl_valid", wb_valid_o, 0);
    check("fl_stall", stall_o, 0);
    check("fl_redirect", redirect_o, 0);
    check("fl_bp_update", bp_update_o, 0);
    wb_ready_i = 1'b1;

    // exception on a mispredicting branch
    send(0, 1, 1, 39'h7000, 39'h7004, 64'h7100, 6'd9, 6'd30, 1, 4'd2);
    check("exc_flag", wb_exception_o, 1);
    check("exc_ecause", wb_ecause_o, 2);
    check("exc_redirect", redirect_o, 0);
    check("exc_we", wb_we_o, 0);
    idle(1);

    // mixed stream with intermittent ready
    for (int i = 0; i < 16; i++) begin
      logic [VA-1:0] pc;
      int t;
      t = i % 4;
      pc = 39'h10000 + 39'(i * 16);
      wb_ready_i = (i % 3 != 0);
      send(t == 2, t == 1 || t == 3, i[1], pc, i[0] ? pc + 39'd4 : pc + 39'h40,
           (t == 0) ? {$urandom, $urandom} : {25'd0, pc + 39'h40},
           6'(i), 6'(i + 32), t == 3, 4'(i));
    end
    wb_ready_i = 1'b1;
    idle(3);

    // asynchronous reset mid-operation
    wb_ready_i = 1'b0;
    send(0, 0, 0, 39'h800, 39'h804, 64'hC1, 6'd1, 6'd1, 0, 4'd0);
    send(0, 1, 1, 39'h804, 39'h808, 64'h900, 6'd2, 6'd2, 0, 4'd0);
    #2 rstn = 1'b0;
    #1;
    check("arst_valid", wb_valid_o, 0);
    check("arst_stall", stall_o, 0);
    check("arst_data", wb_data_o, 0);
    check("arst_redirect", redirect_o, 0);
    idle(1);
    rstn = 1'b1;
    wb_ready_i = 1'b1;
    send(0, 0, 0, 39'h900, 39'h904, 64'hD1, 6'd3, 6'd3, 0, 4'd0);
    check("post_rst_data", wb_data_o, 64'hD1);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
